music_fragment_stitcher: RTL and testbench

//   Downstream of fragment generation. Streams the DEG_FRAG_DECOMP generated fragments in order.
//   For each fragment it trims glue_start notes from the head and glue_end notes from the tail.
//   The kept notes are concatenated into one output song stream, capped at SONG_OUTPUT_LEN notes.

---
 rtl/music_fragment_stitcher.sv | 189 ++++++++++++++++++
 tb/tb_music_fragment_stitcher.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_fragment_stitcher.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | music_fragment_stitcher                                                   |
// | Trims glue notes from each generated fragment and concatenates the kept   |
// | notes into one capped output song stream.                                 |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module music_fragment_stitcher #(
   parameter int SONG_DIM        = 4,
   parameter int BIT_LEN         = 8,
   parameter int DEG_FRAG_DECOMP = 4,
   parameter int SONG_OUTPUT_LEN = 256
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 hdr_valid,
   output logic                                 hdr_ready,
   input  logic [BIT_LEN-1:0]                   hdr_len,
   input  logic [BIT_LEN-1:0]                   hdr_glue_start,
   input  logic [BIT_LEN-1:0]                   hdr_glue_end,
   input  logic                                 note_in_valid,
   output logic                                 note_in_ready,
   input  logic [SONG_DIM*BIT_LEN-1:0]          note_in,
   output logic                                 note_out_valid,
   input  logic                                 note_out_ready,
   output logic [SONG_DIM*BIT_LEN-1:0]          note_out,
   output logic                                 note_out_last,
   output logic                                 song_done,
   output logic [$clog2(SONG_OUTPUT_LEN+1)-1:0] out_count,
   output logic                                 err_glue
);

   localparam int c_noteW = SONG_DIM * BIT_LEN;
   localparam int c_cntW  = $clog2(SONG_OUTPUT_LEN + 1);
   localparam int c_idxW  = $clog2(DEG_FRAG_DECOMP + 1);
   localparam int c_extW  = BIT_LEN + 1;
   localparam logic [c_cntW-1:0] c_maxNotes = c_cntW'(SONG_OUTPUT_LEN);
   localparam logic [c_idxW-1:0] c_lastFrag = c_idxW'(DEG_FRAG_DECOMP);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_BODY = 3'd2,
      S_NEXT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              r_state;
   logic [BIT_LEN-1:0]  r_len;
   logic [BIT_LEN-1:0]  r_glueStart;
   logic [BIT_LEN-1:0]  r_glueEnd;
   logic [BIT_LEN-1:0]  r_pos;
   logic                r_dropAll;
   logic [c_idxW-1:0]   r_fragIdx;
   logic [c_cntW-1:0]   r_outCount;
   logic [c_noteW-1:0]  r_noteOut;
   logic                r_noteOutValid;
   logic                r_noteOutLast;
   logic                r_songDone;
   logic                r_errGlue;

   logic [c_extW-1:0]   w_posExt;
   logic [c_extW-1:0]   w_glueSum;
   logic                w_inWindow;
   logic                w_capHit;
   logic                w_keep;
   logic                w_lastPos;
   logic                w_lastKept;
   logic                w_finalNote;
   logic                w_outFire;
   logic                w_inReady;
   logic                w_inFire;
   logic                w_hdrFire;

   // All glue arithmetic is one bit wider than the fields so sums never wrap.
   assign w_posExt    = {1'b0, r_pos};
   assign w_glueSum   = {1'b0, hdr_glue_start} + {1'b0, hdr_glue_end};
   assign w_inWindow  = (w_posExt >= {1'b0, r_glueStart}) &&
                        ((w_posExt + {1'b0, r_glueEnd}) < {1'b0, r_len});
   assign w_capHit    = (r_outCount == c_maxNotes);
   assign w_keep      = (r_state == S_BODY) && !r_dropAll && w_inWindow && !w_capHit;
   assign w_lastPos   = ((w_posExt + c_extW'(1)) == {1'b0, r_len});
   assign w_lastKept  = ((w_posExt + {1'b0, r_glueEnd} + c_extW'(1)) == {1'b0, r_len});
   assign w_finalNote = ((r_outCount + c_cntW'(1)) == c_maxNotes) ||
                        ((r_fragIdx == c_lastFrag) && w_lastKept);

   assign w_outFire = r_noteOutValid && note_out_ready;
   assign w_inReady = (r_state == S_BODY) && (!w_keep || !r_noteOutValid || note_out_ready);
   assign w_inFire  = note_in_valid && w_inReady;
   assign w_hdrFire = hdr_valid && (r_state == S_HDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_len          <= '0;
         r_glueStart    <= '0;
         r_glueEnd      <= '0;
         r_pos          <= '0;
         r_dropAll      <= 1'b0;
         r_fragIdx      <= '0;
         r_outCount     <= '0;
         r_noteOut      <= '0;
         r_noteOutValid <= 1'b0;
         r_noteOutLast  <= 1'b0;
         r_songDone     <= 1'b0;
         r_errGlue      <= 1'b0;
      end else begin
         r_errGlue <= 1'b0;
         // The output register drains in every state; a new load below overrides.
         if (w_outFire) begin
            r_noteOutValid <= 1'b0;
            r_noteOutLast  <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_HDR;
                  r_outCount <= '0;
                  r_fragIdx  <= '0;
                  r_songDone <= 1'b0;
               end
            end

            S_HDR: begin
               if (w_hdrFire) begin
                  r_len       <= hdr_len;
                  r_glueStart <= hdr_glue_start;
                  r_glueEnd   <= hdr_glue_end;
                  r_dropAll   <= (w_glueSum > {1'b0, hdr_len});
                  r_errGlue   <= (w_glueSum > {1'b0, hdr_len});
                  r_pos       <= '0;
                  r_fragIdx   <= r_fragIdx + c_idxW'(1);
                  r_state     <= (hdr_len == '0) ? S_NEXT : S_BODY;
               end
            end

            S_BODY: begin
               if (w_inFire) begin
                  if (w_keep) begin
                     r_noteOut      <= note_in;
                     r_noteOutValid <= 1'b1;
                     r_noteOutLast  <= w_finalNote;
                     r_outCount     <= r_outCount + c_cntW'(1);
                  end
                  r_pos <= r_pos + BIT_LEN'(1);
                  if (w_lastPos) begin
                     r_state <= S_NEXT;
                  end
               end
            end

            S_NEXT: begin
               if ((r_fragIdx == c_lastFrag) || w_capHit) begin
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_HDR;
               end
            end

            S_DONE: begin
               if (start) begin
                  r_state    <= S_HDR;
                  r_outCount <= '0;
                  r_fragIdx  <= '0;
                  r_songDone <= 1'b0;
               end else begin
                  // Completion is flagged only once the final note has left the register.
                  r_songDone <= !r_noteOutValid || w_outFire;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign hdr_ready      = (r_state == S_HDR);
   assign note_in_ready  = w_inReady;
   assign note_out_valid = r_noteOutValid;
   assign note_out       = r_noteOut;
   assign note_out_last  = r_noteOutLast;
   assign song_done      = r_songDone;
   assign out_count      = r_outCount;
   assign err_glue       = r_errGlue;

endmodule
`default_nettype wire

// File: tb/tb_music_fragment_stitcher.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_music_fragment_stitcher                                                |
// | Scoreboard bench: stimulus pushes expected notes, a monitor pops them.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_music_fragment_stitcher;

   localparam int NFRAG = 4;
   localparam int CAP   = 256;

   logic        clk;
   logic        rst;
   logic        start;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [7:0]  hdr_len;
   logic [7:0]  hdr_glue_start;
   logic [7:0]  hdr_glue_end;
   logic        note_in_valid;
   logic        note_in_ready;
   logic [31:0] note_in;
   logic        note_out_valid;
   logic        note_out_ready;
   logic [31:0] note_out;
   logic        note_out_last;
   logic        song_done;
   logic [8:0]  out_count;
   logic        err_glue;

   typedef struct packed {
      logic [31:0] note;
      logic        last;
   } exp_t;

   exp_t       expQ[$];
   int         nTests = 0;
   int         nFails = 0;
   int         nOut   = 0;
   int         mCnt   = 0;
   int         mFrag  = 0;
   bit         randReady = 0;
   logic [7:0] songTag = 8'd0;

   music_fragment_stitcher #(
      .SONG_DIM(4), .BIT_LEN(8), .DEG_FRAG_DECOMP(NFRAG), .SONG_OUTPUT_LEN(CAP)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_len(hdr_len),
      .hdr_glue_start(hdr_glue_start), .hdr_glue_end(hdr_glue_end),
      .note_in_valid(note_in_valid), .note_in_ready(note_in_ready), .note_in(note_in),
      .note_out_valid(note_out_valid), .note_out_ready(note_out_ready), .note_out(note_out),
      .note_out_last(note_out_last), .song_done(song_done), .out_count(out_count),
      .err_glue(err_glue)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      nTests++;
      nFails++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Downstream ready: constant 1, or a coin flip each cycle.
   initial begin
      note_out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         note_out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && note_out_valid && note_out_ready) begin
         nOut++;
         if (expQ.size() == 0) begin
            nTests++;
            nFails++;
            $display("FAIL unexpected_note: got %0h expected none", note_out);
         end else begin
            e = expQ.pop_front();
            check("note_data", note_out, e.note);
            check("note_last", note_out_last, e.last);
         end
      end
   end

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
      mCnt  = 0;
      mFrag = 0;
      check("start_clears_done", song_done, 0);
      check("start_clears_count", out_count, 0);
   endtask

   task automatic sendHdr(input int len, input int gs, input int ge, output bit ok);
      hdr_len        = 8'(len);
      hdr_glue_start = 8'(gs);
      hdr_glue_end   = 8'(ge);
      hdr_valid      = 1'b1;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
         if (hdr_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (ok) tick();
      hdr_valid = 1'b0;
      if (!ok) failNow("hdr_accept");
      else check("err_glue", err_glue, (gs + ge > len) ? 1 : 0);
   endtask

   task automatic feedNote(input logic [31:0] data);
      bit ok = 0;
      note_in_valid = 1'b1;
      note_in       = data;
      for (int t = 0; t < 200; t++) begin
         if (note_in_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (ok) tick();
      else failNow("note_accept");
      note_in_valid = 1'b0;
   endtask

   task automatic sendFrag(input int len, input int gs, input int ge);
      bit          ok;
      bit          drop;
      int          f;
      exp_t        e;
      logic [31:0] data;
      logic [7:0]  fb;
      logic [7:0]  pb;
      f     = mFrag;
      mFrag = mFrag + 1;
      drop  = (gs + ge > len);
      sendHdr(len, gs, ge, ok);
      if (ok) begin
         for (int pos = 0; pos < len; pos++) begin
            fb   = 8'(f);
            pb   = 8'(pos);
            data = {songTag, fb, pb, 8'h5A};
            if (!drop && pos >= gs && pos + ge < len && mCnt < CAP) begin
               e.note = data;
               e.last = (mCnt + 1 == CAP) || (f == NFRAG - 1 && pos == len - ge - 1);
               expQ.push_back(e);
               mCnt++;
            end
            feedNote(data);
         end
      end
   endtask

   task automatic waitDone(input int expCount, input int base);
      bit ok = 0;
      for (int t = 0; t < 3000; t++) begin
         if (song_done) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) failNow("song_done");
      check("done_queue_empty", expQ.size(), 0);
      check("out_count", out_count, expCount);
      check("notes_seen", nOut - base, expCount);
      check("done_out_empty", note_out_valid, 0);
      check("done_hdr_ready", hdr_ready, 0);
   endtask

   initial begin
      int          base;
      exp_t        e;
      logic [31:0] data;
      logic [7:0]  pb;
      rst = 1'b1; start = 1'b0; hdr_valid = 1'b0; hdr_len = '0;
      hdr_glue_start = '0; hdr_glue_end = '0; note_in_valid = 1'b0; note_in = '0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", {hdr_ready, note_in_ready, note_out_valid, note_out_last,
                              song_done, err_glue, out_count, note_out}, 0);
      rst = 1'b0;
      tick();

      // Four fragments, one note trimmed at each end: 24 notes.
      songTag = 8'd1; base = nOut;
      pulseStart();
      for (int i = 0; i < NFRAG; i++) sendFrag(8, 1, 1);
      waitDone(24, base);

      // Over-glued fragment, full fragment, empty fragment, short tail fragment.
      songTag = 8'd2; base = nOut;
      pulseStart();
      sendFrag(4, 3, 2);
      sendFrag(5, 0, 0);
      sendFrag(0, 0, 0);
      check("len0_next_not_ready", hdr_ready, 0);
      tick();
      check("len0_hdr_ready_again", hdr_ready, 1);
      sendFrag(3, 1, 0);
      waitDone(7, base);

      // Same song as the first, with a stalling downstream.
      randReady = 1; songTag = 8'd1; base = nOut;
      pulseStart();
      for (int i = 0; i < NFRAG; i++) sendFrag(8, 1, 1);
      waitDone(24, base);
      randReady = 0;
      tick();

      // Cap reached mid-fragment: remainder of fragment 1 is consumed and dropped.
      songTag = 8'd4; base = nOut;
      pulseStart();
      sendFrag(200, 0, 0);
      sendFrag(200, 0, 0);
      waitDone(CAP, base);

      // Reset with a note pending in the output register.
      songTag = 8'd5; base = nOut;
      pulseStart();
      begin
         bit ok;
         sendHdr(8, 0, 0, ok);
         for (int pos = 0; pos < 4; pos++) begin
            pb   = 8'(pos);
            data = {songTag, 8'h00, pb, 8'h5A};
            if (pos < 3) begin
               e.note = data;
               e.last = 1'b0;
               expQ.push_back(e);
            end
            feedNote(data);
         end
      end
      check("pre_reset_notes", nOut - base, 3);
      rst = 1'b1;
      #1;
      check("midsong_reset_outputs", {hdr_ready, note_in_ready, note_out_valid, note_out_last,
                                      song_done, err_glue, out_count, note_out}, 0);
      check("reset_queue_empty", expQ.size(), 0);
      tick();
      rst = 1'b0;
      tick();

      songTag = 8'd6; base = nOut;
      pulseStart();
      for (int i = 0; i < NFRAG; i++) sendFrag(2, 0, 0);
      waitDone(8, base);

      $display("[TB] %0d tests run, %0d failed", nTests, nFails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
